// File: rtl/count_sequence_checker.sv
// Receive-side decoder and integrity checker for the 4-bit arbitrary-sequence counter.
// Maps codes 0,2,5,9,3,11,8,1 to positions 0..7, acquires lock, flags errors and counts wraps.
module count_sequence_checker #(
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned ERR_LIMIT  = 2,
   parameter int unsigned ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [3:0]           code,
   input  logic                 clear_err,
   output logic [2:0]           index,
   output logic                 index_valid,
   output logic                 locked,
   output logic                 illegal,
   output logic                 seq_err,
   output logic                 wrap,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [ERR_CNT_W-1:0] wrap_count
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LOCK_CNT_V = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] ERR_LIM_V  = CNT_W'(ERR_LIMIT);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_SYNC   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [1:0]           state, state_next;
   logic [CNT_W-1:0]     good_cnt, good_next, good_inc;
   logic [CNT_W-1:0]     bad_cnt, bad_next, bad_inc;
   logic [2:0]           prev_idx, prev_next, succ_idx;
   logic [2:0]           index_next;
   logic                 valid_next, locked_next;
   logic                 illegal_next, seq_err_next, wrap_next;
   logic                 err_inc, wrap_inc;
   logic [ERR_CNT_W-1:0] err_next, wrap_cnt_next;
   logic [2:0]           dec_idx;
   logic                 dec_legal, sample_legal, sample_illegal, match;

   // Code-to-position decode; anything outside the sequence is illegal.
   always_comb begin
      dec_legal = 1'b1;
      dec_idx   = 3'd0;
      case (code)
         4'd0:    dec_idx = 3'd0;
         4'd2:    dec_idx = 3'd1;
         4'd5:    dec_idx = 3'd2;
         4'd9:    dec_idx = 3'd3;
         4'd3:    dec_idx = 3'd4;
         4'd11:   dec_idx = 3'd5;
         4'd8:    dec_idx = 3'd6;
         4'd1:    dec_idx = 3'd7;
         default: dec_legal = 1'b0;
      endcase
   end

   assign succ_idx       = 3'(prev_idx + 3'd1);
   assign sample_legal   = en & dec_legal;
   assign sample_illegal = en & ~dec_legal;
   assign match          = dec_legal && (dec_idx == succ_idx);
   assign good_inc       = CNT_W'(good_cnt + 1'b1);
   assign bad_inc        = CNT_W'(bad_cnt + 1'b1);

   // State register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_HUNT;
         good_cnt    <= '0;
         bad_cnt     <= '0;
         prev_idx    <= '0;
         index       <= '0;
         index_valid <= 1'b0;
         locked      <= 1'b0;
         illegal     <= 1'b0;
         seq_err     <= 1'b0;
         wrap        <= 1'b0;
         err_count   <= '0;
         wrap_count  <= '0;
      end else begin
         state       <= state_next;
         good_cnt    <= good_next;
         bad_cnt     <= bad_next;
         prev_idx    <= prev_next;
         index       <= index_next;
         index_valid <= valid_next;
         locked      <= locked_next;
         illegal     <= illegal_next;
         seq_err     <= seq_err_next;
         wrap        <= wrap_next;
         err_count   <= err_next;
         wrap_count  <= wrap_cnt_next;
      end
   end

   // Next-state logic; the unused encoding falls back to HUNT unconditionally.
   always_comb begin
      state_next = state;
      case (state)
         ST_HUNT: begin
            if (sample_legal) state_next = ST_SYNC;
         end
         ST_SYNC: begin
            if (sample_illegal)
               state_next = ST_HUNT;
            else if (sample_legal && match && (good_inc == LOCK_CNT_V))
               state_next = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (en && !match && (bad_inc == ERR_LIM_V)) state_next = ST_HUNT;
         end
         default: state_next = ST_HUNT;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      good_next    = good_cnt;
      bad_next     = bad_cnt;
      prev_next    = prev_idx;
      index_next   = index;
      valid_next   = index_valid;
      locked_next  = locked;
      illegal_next = sample_illegal;
      seq_err_next = 1'b0;
      wrap_next    = 1'b0;
      err_inc      = 1'b0;
      wrap_inc     = 1'b0;

      if (sample_legal) begin
         index_next = dec_idx;
         valid_next = 1'b1;
      end

      case (state)
         ST_HUNT: begin
            if (sample_legal) begin
               prev_next = dec_idx;
               good_next = '0;
            end
         end
         ST_SYNC: begin
            if (sample_legal) begin
               prev_next = dec_idx;
               if (match) begin
                  good_next = good_inc;
                  if (good_inc == LOCK_CNT_V) begin
                     locked_next = 1'b1;
                     bad_next    = '0;
                  end
               end else begin
                  good_next = '0;
               end
            end else if (sample_illegal) begin
               good_next = '0;
            end
         end
         ST_LOCKED: begin
            if (en) begin
               if (match) begin
                  bad_next  = '0;
                  prev_next = dec_idx;
                  if (prev_idx == 3'd7) begin
                     wrap_next = 1'b1;
                     wrap_inc  = 1'b1;
                  end
               end else begin
                  seq_err_next = 1'b1;
                  err_inc      = 1'b1;
                  bad_next     = bad_inc;
                  // Flywheel past an illegal code so a single glitch costs one error.
                  prev_next    = dec_legal ? dec_idx : succ_idx;
                  if (bad_inc == ERR_LIM_V) begin
                     locked_next = 1'b0;
                     bad_next    = '0;
                     good_next   = '0;
                  end
               end
            end
         end
         default: locked_next = 1'b0;
      endcase

      // Saturating counters; clear wins over a coincident increment.
      if (clear_err)
         err_next = '0;
      else if (err_inc && (err_count != '1))
         err_next = ERR_CNT_W'(err_count + 1'b1);
      else
         err_next = err_count;

      if (clear_err)
         wrap_cnt_next = '0;
      else if (wrap_inc && (wrap_count != '1))
         wrap_cnt_next = ERR_CNT_W'(wrap_count + 1'b1);
      else
         wrap_cnt_next = wrap_count;
   end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed plus randomized bench for count_sequence_checker against a behavioural model.
module tb_count_sequence_checker;
   localparam int LOCK_COUNT = 3;
   localparam int ERR_LIMIT  = 2;
   localparam int ERR_CNT_W  = 8;
   localparam int SAT        = (1 << ERR_CNT_W) - 1;

   logic                 clk;
   logic                 reset;
   logic                 en;
   logic [3:0]           code;
   logic                 clear_err;
   logic [2:0]           index;
   logic                 index_valid;
   logic                 locked;
   logic                 illegal;
   logic                 seq_err;
   logic                 wrap;
   logic [ERR_CNT_W-1:0] err_count;
   logic [ERR_CNT_W-1:0] wrap_count;

   count_sequence_checker #(
      .LOCK_COUNT(LOCK_COUNT),
      .ERR_LIMIT (ERR_LIMIT),
      .ERR_CNT_W (ERR_CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .code       (code),
      .clear_err  (clear_err),
      .index      (index),
      .index_valid(index_valid),
      .locked     (locked),
      .illegal    (illegal),
      .seq_err    (seq_err),
      .wrap       (wrap),
      .err_count  (err_count),
      .wrap_count (wrap_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;
   int seq_tab[8] = '{0, 2, 5, 9, 3, 11, 8, 1};

   // Behavioural model: mode 0 = hunting, 1 = syncing, 2 = locked.
   int m_mode, m_good, m_bad, m_prev, m_errs, m_wraps;
   int e_index, e_valid, e_illegal, e_seq_err, e_wrap;

   function automatic int find_pos(input logic [3:0] c);
      for (int i = 0; i < 8; i++)
         if (seq_tab[i] == int'(c)) return i;
      return -1;
   endfunction

   function automatic logic [3:0] code_at(input int p);
      return 4'(seq_tab[p % 8]);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_good = 0; m_bad = 0; m_prev = 0; m_errs = 0; m_wraps = 0;
      e_index = 0; e_valid = 0; e_illegal = 0; e_seq_err = 0; e_wrap = 0;
   endtask

   task automatic model_step(input logic e, input logic [3:0] c, input logic clr);
      int pos, nxt;
      e_illegal = 0; e_seq_err = 0; e_wrap = 0;
      if (e) begin
         pos = find_pos(c);
         nxt = (m_prev + 1) % 8;
         if (pos >= 0) begin
            e_index = pos; e_valid = 1;
         end else begin
            e_illegal = 1;
         end
         if (m_mode == 0) begin
            if (pos >= 0) begin m_prev = pos; m_good = 0; m_mode = 1; end
         end else if (m_mode == 1) begin
            if (pos < 0) begin
               m_mode = 0; m_good = 0;
            end else begin
               if (pos == nxt) begin
                  m_good++;
                  if (m_good == LOCK_COUNT) begin m_mode = 2; m_bad = 0; end
               end else begin
                  m_good = 0;
               end
               m_prev = pos;
            end
         end else begin
            if (pos == nxt) begin
               m_bad = 0;
               if (m_prev == 7) begin
                  e_wrap = 1;
                  m_wraps = (m_wraps < SAT) ? m_wraps + 1 : SAT;
               end
               m_prev = pos;
            end else begin
               e_seq_err = 1;
               m_errs = (m_errs < SAT) ? m_errs + 1 : SAT;
               m_bad++;
               m_prev = (pos >= 0) ? pos : nxt;
               if (m_bad == ERR_LIMIT) begin m_mode = 0; m_bad = 0; m_good = 0; end
            end
         end
      end
      if (clr) begin m_errs = 0; m_wraps = 0; end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      check({where, ".index"},       32'(index),       32'(e_index));
      check({where, ".index_valid"}, 32'(index_valid), 32'(e_valid));
      check({where, ".locked"},      32'(locked),      32'(m_mode == 2));
      check({where, ".illegal"},     32'(illegal),     32'(e_illegal));
      check({where, ".seq_err"},     32'(seq_err),     32'(e_seq_err));
      check({where, ".wrap"},        32'(wrap),        32'(e_wrap));
      check({where, ".err_count"},   32'(err_count),   32'(m_errs));
      check({where, ".wrap_count"},  32'(wrap_count),  32'(m_wraps));
   endtask

   // One sampling cycle: drive at negedge, model at posedge, check at the following negedge.
   task automatic cyc(input logic e, input logic [3:0] c, input logic clr, input string tag);
      en = e; code = c; clear_err = clr;
      @(posedge clk);
      model_step(e, c, clr);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic lock_from(input int p, input string tag);
      for (int k = 0; k < 4; k++) cyc(1'b1, code_at(p + k), 1'b0, tag);
   endtask

   initial begin
      int p, r;
      logic [3:0] c;
      logic e, clr;

      reset = 1'b1; en = 1'b0; code = 4'd0; clear_err = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      reset = 1'b0;

      // Acquire lock on 0,2,5,9.
      cyc(1'b1, 4'd0, 1'b0, "acq0");
      cyc(1'b1, 4'd2, 1'b0, "acq2");
      cyc(1'b1, 4'd5, 1'b0, "acq5");
      check("pre_lock", 32'(locked), 32'd0);
      cyc(1'b1, 4'd9, 1'b0, "acq9");
      check("lock_after_9", 32'(locked), 32'd1);
      check("index_after_9", 32'(index), 32'd3);

      // Run through the wrap.
      cyc(1'b1, 4'd3,  1'b0, "run3");
      cyc(1'b1, 4'd11, 1'b0, "run11");
      cyc(1'b1, 4'd8,  1'b0, "run8");
      cyc(1'b1, 4'd1,  1'b0, "run1");
      cyc(1'b1, 4'd0,  1'b0, "run0");
      check("wrap_pulse", 32'(wrap), 32'd1);
      check("wrap_count1", 32'(wrap_count), 32'd1);

      // Illegal code then wrong code drops lock.
      cyc(1'b1, 4'd2, 1'b0, "pre2");
      cyc(1'b1, 4'd5, 1'b0, "pre5");
      cyc(1'b1, 4'd9, 1'b0, "pre9");
      cyc(1'b1, 4'd7, 1'b0, "ill7");
      check("ill7_index_held", 32'(index), 32'd3);
      cyc(1'b1, 4'd3, 1'b0, "mis3");
      check("drop_lock", 32'(locked), 32'd0);
      check("err_count2", 32'(err_count), 32'd2);

      // Relock, then hold en low with a wandering code.
      lock_from(4, "relock");
      for (int k = 0; k < 5; k++) cyc(1'b0, 4'($urandom_range(0, 15)), 1'b0, "hold");
      cyc(1'b1, code_at(m_prev + 1), 1'b0, "resume");
      check("resume_locked", 32'(locked), 32'd1);

      // Saturate err_count via repeated lock/drop rounds.
      for (int n = 0; n < 130; n++) begin
         p = $urandom_range(0, 7);
         lock_from(p, "sat_lock");
         cyc(1'b1, code_at(p + 3), 1'b0, "sat_rep");
         cyc(1'b1, code_at(p + 3), 1'b0, "sat_rep");
      end
      check("err_saturated", 32'(err_count), 32'(SAT));
      p = $urandom_range(0, 7);
      lock_from(p, "clr_lock");
      cyc(1'b1, code_at(p + 3), 1'b1, "clr_mis");
      check("clear_priority", 32'(err_count), 32'd0);
      check("clear_seq_err", 32'(seq_err), 32'd1);

      // Random traffic biased toward the expected successor.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      c = code_at(m_prev + 1);
         else if (r < 85) c = code_at($urandom_range(0, 7));
         else             c = 4'($urandom_range(0, 15));
         e   = ($urandom_range(0, 9) != 0);
         clr = e && ($urandom_range(0, 49) == 0);
         cyc(e, c, clr, "rand");
      end

      // Asynchronous reset while locked, between clock edges.
      lock_from(0, "pre_arst");
      cyc(1'b1, code_at(4), 1'b0, "pre_arst");
      cyc(1'b1, code_at(5), 1'b0, "pre_arst");
      cyc(1'b1, code_at(6), 1'b0, "pre_arst");
      cyc(1'b1, code_at(7), 1'b0, "pre_arst");
      cyc(1'b1, code_at(0), 1'b0, "pre_arst");
      check("pre_arst_locked", 32'(locked), 32'd1);
      @(posedge clk);
      model_step(1'b1, code, 1'b0);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all("arst");
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b1, 4'd2, 1'b0, "post2");
      cyc(1'b1, 4'd5, 1'b0, "post5");
      cyc(1'b1, 4'd9, 1'b0, "post9");
      check("post_not_locked", 32'(locked), 32'd0);
      cyc(1'b1, 4'd3, 1'b0, "post3");
      check("post_locked", 32'(locked), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
